// File: rtl/ram_burst_reader_if.sv
// Bus bundle for ram_burst_reader: the RAM read port and the output
// valid/ready stream. The reader drives through "master"; the RAM and the
// downstream consumer sit on "slave".
interface ram_burst_reader_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8
);
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_rd;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  modport master (
    output ram_addr, ram_rd, out_data, out_valid,
    input  ram_rdata, out_ready
  );

  modport slave (
    input  ram_addr, ram_rd, out_data, out_valid,
    output ram_rdata, out_ready
  );
endinterface

// File: rtl/ram_burst_reader.sv
// Burst read initiator for the 64KB byte-wide RAM. A start command issues
// sequential single-cycle reads. Returned words go out on a valid/ready
// stream through a 2-entry buffer. A word arriving while the buffer is empty
// is presented directly as the buffer head, so the first word appears two
// cycles after start and a ready consumer gets one word per cycle.
// Issue credits (buffered words + read in flight < 2) keep the buffer from
// ever overflowing.
module ram_burst_reader #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 17
) (
  input  logic              clk,
  input  logic              reset_,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  ram_burst_reader_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  localparam logic [LEN_W-1:0]  LEN_ONE  = LEN_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

  state_t            state;
  logic [ADDR_W-1:0] addr_cnt;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_rd_q;
  logic [LEN_W-1:0]  issue_cnt;
  logic [LEN_W-1:0]  ret_cnt;
  logic              pending;
  logic [DATA_W-1:0] buf_mem [2];
  logic              rd_ptr;
  logic              wr_ptr;
  logic [1:0]        count;

  logic              out_valid;
  logic              bypass;
  logic              xfer;
  logic              push;
  logic              pop_head;
  logic              credit;
  logic [1:0]        count_next;

  // pending marks the cycle in which ram_rdata holds a word we asked for
  assign bypass        = pending && (count == 2'd0);
  assign out_valid     = pending || (count != 2'd0);
  assign bus.out_valid = out_valid;
  assign bus.out_data  = bypass ? bus.ram_rdata : buf_mem[rd_ptr];
  assign bus.ram_addr  = ram_addr_q;
  assign bus.ram_rd    = ram_rd_q;

  assign xfer       = out_valid && bus.out_ready;
  assign push       = pending && !(bypass && xfer);
  assign pop_head   = xfer && (count != 2'd0);
  assign count_next = count + {1'b0, push} - {1'b0, pop_head};
  assign credit     = ({1'b0, count_next} + {2'b00, ram_rd_q}) < 3'd2;

  // Burst control FSM with the buffer, counters and registered bus outputs
  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      ram_rd_q   <= 1'b0;
      ram_addr_q <= '0;
      addr_cnt   <= '0;
      issue_cnt  <= '0;
      ret_cnt    <= '0;
      pending    <= 1'b0;
      count      <= 2'd0;
      rd_ptr     <= 1'b0;
      wr_ptr     <= 1'b0;
      buf_mem[0] <= '0;
      buf_mem[1] <= '0;
    end else begin
      done <= 1'b0;
      if (state != IDLE && abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        ram_rd_q  <= 1'b0;
        pending   <= 1'b0;
        count     <= 2'd0;
        rd_ptr    <= 1'b0;
        wr_ptr    <= 1'b0;
        issue_cnt <= '0;
        ret_cnt   <= '0;
      end else begin
        pending <= ram_rd_q;
        count   <= count_next;
        if (push) begin
          buf_mem[wr_ptr] <= bus.ram_rdata;
          wr_ptr          <= ~wr_ptr;
        end
        if (pop_head) begin
          rd_ptr <= ~rd_ptr;
        end

        case (state)
          IDLE: begin
            ram_rd_q <= 1'b0;
            if (start) begin
              if (len == '0) begin
                done <= 1'b1;
              end else begin
                busy       <= 1'b1;
                ram_rd_q   <= 1'b1;
                ram_addr_q <= start_addr;
                addr_cnt   <= start_addr + ADDR_ONE;
                issue_cnt  <= len - LEN_ONE;
                ret_cnt    <= len;
                state      <= (len == LEN_ONE) ? DRAIN : ISSUE;
              end
            end
          end
          ISSUE: begin
            if (issue_cnt == '0) begin
              ram_rd_q <= 1'b0;
              state    <= DRAIN;
            end else if (credit) begin
              ram_rd_q   <= 1'b1;
              ram_addr_q <= addr_cnt;
              addr_cnt   <= addr_cnt + ADDR_ONE;
              issue_cnt  <= issue_cnt - LEN_ONE;
              if (issue_cnt == LEN_ONE) begin
                state <= DRAIN;
              end
            end else begin
              ram_rd_q <= 1'b0;
            end
          end
          DRAIN: begin
            ram_rd_q <= 1'b0;
          end
          default: begin
            state <= IDLE;
          end
        endcase

        if (state != IDLE && xfer) begin
          ret_cnt <= ret_cnt - LEN_ONE;
          if (ret_cnt == LEN_ONE) begin
            done     <= 1'b1;
            busy     <= 1'b0;
            ram_rd_q <= 1'b0;
            state    <= IDLE;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_burst_reader.sv
// Testbench for ram_burst_reader: a byte RAM model with 1-cycle read latency
// drives the slave side of the bus. Stimulus pushes expected addresses and
// data into queues; a negedge monitor pops and compares them.
module tb_ram_burst_reader;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 17;

  logic              clk = 1'b0;
  logic              reset_ = 1'b1;
  logic              start = 1'b0;
  logic [ADDR_W-1:0] start_addr = '0;
  logic [LEN_W-1:0]  len = '0;
  logic              abort = 1'b0;
  logic              busy;
  logic              done;

  ram_burst_reader_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_burst_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .reset_     (reset_),
    .start      (start),
    .start_addr (start_addr),
    .len        (len),
    .abort      (abort),
    .busy       (busy),
    .done       (done),
    .bus        (bus)
  );

  logic [DATA_W-1:0] ram [0:65535];

  int checks = 0;
  int errors = 0;
  int xfer_total = 0;
  int done_total = 0;
  int rd_total = 0;
  int outstanding = 0;
  logic prev_stall = 1'b0;
  logic prev_abort = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  logic [DATA_W-1:0] exp_data_q [$];
  logic [ADDR_W-1:0] exp_addr_q [$];

  always #5 clk = ~clk;

  // RAM model: read data appears the cycle after ram_rd
  always @(posedge clk) begin
    if (bus.ram_rd) bus.ram_rdata <= ram[bus.ram_addr];
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic reportFail(input string name, input string what);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got %s, want none", name, what);
  endtask

  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input logic [LEN_W-1:0] n);
    for (int i = 0; i < int'(n); i++) begin
      logic [ADDR_W-1:0] a;
      a = addr + ADDR_W'(i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(ram[a]);
    end
    @(posedge clk); #1;
    start      = 1'b1;
    start_addr = addr;
    len        = n;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic waitIdle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(posedge clk); #1;
      if (!busy && exp_data_q.size() == 0) begin
        repeat (2) begin @(posedge clk); #1; end
        return;
      end
    end
    checks++;
    errors++;
    $display("[TB] FAIL wait_idle: timed out after %0d cycles, want idle with all words returned", budget);
  endtask

  // Monitor: compares reads and transfers against the expectation queues
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_) begin
        outstanding = 0;
        prev_stall  = 1'b0;
        prev_abort  = 1'b0;
      end else begin
        if (prev_abort) begin
          outstanding = 0;
          prev_stall  = 1'b0;
        end
        if (bus.ram_rd) begin
          rd_total++;
          outstanding++;
          checkOutput("words_held_le2", 32'(outstanding <= 2), 32'd1);
          if (exp_addr_q.size() == 0) reportFail("unexpected_ram_rd", "a read");
          else checkOutput("ram_addr", 32'(bus.ram_addr), 32'(exp_addr_q.pop_front()));
        end
        if (prev_stall) begin
          checkOutput("valid_held_in_stall", 32'(bus.out_valid), 32'd1);
          checkOutput("data_stable_in_stall", 32'(bus.out_data), 32'(prev_data));
        end
        if (bus.out_valid && bus.out_ready && !abort) begin
          xfer_total++;
          outstanding--;
          if (exp_data_q.size() == 0) reportFail("unexpected_word", "a word");
          else checkOutput("out_data", 32'(bus.out_data), 32'(exp_data_q.pop_front()));
        end
        if (done) done_total++;
        prev_stall = bus.out_valid && !bus.out_ready;
        prev_data  = bus.out_data;
        prev_abort = abort && busy;
      end
    end
  end

  // Safety net against a hung DUT
  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: got still running, want finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  // Directed test sequence
  initial begin
    int xb, db, rb;
    logic [6:0] t_rd, t_valid, t_done, t_busy;
    logic [5:0] ready_pat;

    for (int a = 0; a < 65536; a++) ram[a] = a[7:0];
    bus.out_ready = 1'b1;

    // Reset state
    #2 reset_ = 1'b0;
    #20;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_ram_rd", 32'(bus.ram_rd), 32'd0);
    checkOutput("reset_ram_addr", 32'(bus.ram_addr), 32'd0);
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_out_data", 32'(bus.out_data), 32'd0);
    @(posedge clk); #1;
    reset_ = 1'b1;
    @(posedge clk); #1;

    // Basic burst: cycle-by-cycle table starting the cycle after start
    $display("[TB] basic burst 0x0100 len 4");
    xb = xfer_total; db = done_total;
    t_rd    = 7'b0001111;
    t_valid = 7'b0011110;
    t_done  = 7'b0100000;
    t_busy  = 7'b0011111;
    applyStimulus(16'h0100, 17'd4);
    for (int i = 0; i < 7; i++) begin
      checkOutput("basic_ram_rd", 32'(bus.ram_rd), 32'(t_rd[i]));
      checkOutput("basic_out_valid", 32'(bus.out_valid), 32'(t_valid[i]));
      checkOutput("basic_done", 32'(done), 32'(t_done[i]));
      checkOutput("basic_busy", 32'(busy), 32'(t_busy[i]));
      if (t_rd[i]) checkOutput("basic_addr", 32'(bus.ram_addr), 32'h100 + 32'(i));
      if (t_valid[i]) checkOutput("basic_data", 32'(bus.out_data), 32'(i - 1));
      @(posedge clk); #1;
    end
    checkOutput("basic_words", 32'(xfer_total - xb), 32'd4);
    checkOutput("basic_done_count", 32'(done_total - db), 32'd1);

    // Backpressure: ready pattern 1,0,0,1,0,1 repeating
    $display("[TB] backpressure 0x0010 len 6");
    xb = xfer_total; db = done_total;
    ready_pat = 6'b101001;
    applyStimulus(16'h0010, 17'd6);
    for (int i = 0; i < 30; i++) begin
      bus.out_ready = ready_pat[i % 6];
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    waitIdle(50);
    checkOutput("bp_words", 32'(xfer_total - xb), 32'd6);
    checkOutput("bp_done_count", 32'(done_total - db), 32'd1);

    // Wrap-around: 0xFFFE, 0xFFFF, 0x0000, 0x0001
    $display("[TB] wrap 0xFFFE len 4");
    xb = xfer_total;
    applyStimulus(16'hFFFE, 17'd4);
    waitIdle(50);
    checkOutput("wrap_words", 32'(xfer_total - xb), 32'd4);

    // Zero length
    $display("[TB] zero length");
    rb = rd_total; db = done_total;
    applyStimulus(16'h0300, 17'd0);
    checkOutput("zero_done", 32'(done), 32'd1);
    checkOutput("zero_busy", 32'(busy), 32'd0);
    @(posedge clk); #1;
    checkOutput("zero_done_clear", 32'(done), 32'd0);
    checkOutput("zero_busy_after", 32'(busy), 32'd0);
    checkOutput("zero_reads", 32'(rd_total - rb), 32'd0);
    checkOutput("zero_done_count", 32'(done_total - db), 32'd1);

    // Start while busy is ignored
    $display("[TB] start during busy");
    xb = xfer_total; db = done_total;
    applyStimulus(16'h0020, 17'd5);
    @(posedge clk); #1;
    start = 1'b1; start_addr = 16'h0400; len = 17'd3;
    @(posedge clk); #1;
    start = 1'b0;
    waitIdle(50);
    checkOutput("busy_start_words", 32'(xfer_total - xb), 32'd5);
    checkOutput("busy_start_done", 32'(done_total - db), 32'd1);

    // Abort after 3 transfers with a read in flight
    $display("[TB] abort");
    xb = xfer_total; db = done_total;
    applyStimulus(16'h0050, 17'd10);
    repeat (4) begin @(posedge clk); #1; end
    checkOutput("abort_words_before", 32'(xfer_total - xb), 32'd3);
    abort = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    abort = 1'b0;
    checkOutput("abort_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("abort_busy", 32'(busy), 32'd0);
    checkOutput("abort_done", 32'(done), 32'd0);
    exp_data_q.delete();
    exp_addr_q.delete();
    bus.out_ready = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    checkOutput("abort_no_done", 32'(done_total - db), 32'd0);
    checkOutput("abort_no_stale", 32'(xfer_total - xb), 32'd3);
    applyStimulus(16'h0200, 17'd1);
    waitIdle(50);
    checkOutput("abort_next_words", 32'(xfer_total - xb), 32'd4);
    checkOutput("abort_next_done", 32'(done_total - db), 32'd1);

    // Reset in the middle of a burst
    $display("[TB] reset mid-burst");
    xb = xfer_total;
    applyStimulus(16'h0010, 17'd8);
    repeat (4) begin @(posedge clk); #1; end
    checkOutput("rst_words_before", 32'(xfer_total - xb), 32'd3);
    reset_ = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_ram_rd", 32'(bus.ram_rd), 32'd0);
    checkOutput("rst_ram_addr", 32'(bus.ram_addr), 32'd0);
    checkOutput("rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(bus.out_data), 32'd0);
    exp_data_q.delete();
    exp_addr_q.delete();
    repeat (2) @(posedge clk);
    #1 reset_ = 1'b1;
    @(posedge clk); #1;
    checkOutput("rst_idle", 32'(busy), 32'd0);
    xb = xfer_total;
    applyStimulus(16'h0000, 17'd2);
    waitIdle(50);
    checkOutput("rst_new_words", 32'(xfer_total - xb), 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
